// File: rtl/dc_ddr_pkg.sv
// Shared DDR-side constants and types for the write combiner.
// Line geometry is fixed at 8 x 64-bit words per burst.
package dc_ddr_pkg;

    localparam int DDR_ADDR_W = 29;
    localparam int LINE_WORDS = 8;
    localparam int LINE_IDX_W = 3;

    localparam logic [7:0] BURST_LEN = 8'd8;
    localparam logic [LINE_IDX_W-1:0] LAST_BEAT = LINE_IDX_W'(LINE_WORDS - 1);

    typedef enum logic {
        WC_IDLE,
        WC_FLUSH
    } wc_state_e;

endpackage

// File: rtl/wc_line_buffer.sv
// One-line write buffer: 8 x 64-bit data with per-byte valid mask.
// Byte-merge write port, indexed read port, clear and full flag.
module wc_line_buffer
    import dc_ddr_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [LINE_IDX_W-1:0] wr_idx_i,
    input  logic [63:0]           wr_data_i,
    input  logic [7:0]            wr_be_i,
    input  logic                  clr_i,
    input  logic [LINE_IDX_W-1:0] rd_idx_i,
    output logic [63:0]           rd_data_o,
    output logic [7:0]            rd_be_o,
    output logic                  full_o
);

    logic [63:0] data_q [LINE_WORDS];
    logic [63:0] data_d [LINE_WORDS];
    logic [7:0]  mask_q [LINE_WORDS];
    logic [7:0]  mask_d [LINE_WORDS];

    // clear and write may coincide: the written word then survives alone
    always_comb begin
        full_o = 1'b1;
        for (int i = 0; i < LINE_WORDS; i++) begin
            data_d[i] = clr_i ? '0 : data_q[i];
            mask_d[i] = clr_i ? '0 : mask_q[i];
            if (wr_en_i && wr_idx_i == LINE_IDX_W'(i)) begin
                for (int b = 0; b < 8; b++) begin
                    if (wr_be_i[b]) begin
                        data_d[i][8*b +: 8] = wr_data_i[8*b +: 8];
                    end
                end
                mask_d[i] = mask_d[i] | wr_be_i;
            end
            full_o = full_o & (&mask_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                data_q[i] <= data_d[i];
                mask_q[i] <= mask_d[i];
            end
        end
    end

    assign rd_data_o = data_q[rd_idx_i];
    assign rd_be_o   = mask_q[rd_idx_i];

endmodule

// File: rtl/simple_write_combiner.sv
// Merges byte-enabled core word writes into one line and emits
// full 8-beat DDR bursts; flags reads that hit the unflushed line.
module simple_write_combiner
    import dc_ddr_pkg::*;
#(
    parameter int ADDR_W = DDR_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [63:0]       wr_data_in,
    input  logic [7:0]        wr_be_in,
    input  logic              wr_in,
    input  logic              flush_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_hazard_out,
    output logic              wr_busy_out,
    output logic              flush_done_out,
    output logic [ADDR_W-1:0] ddram_addr_out,
    output logic [7:0]        ddram_burstcnt_out,
    output logic [63:0]       ddram_writedata_out,
    output logic [7:0]        ddram_byteenable_out,
    output logic              ddram_we_out,
    input  logic              ddram_busy_in
);

    localparam int LA_W = ADDR_W - LINE_IDX_W;

    wc_state_e             state_q, state_d;
    logic [LINE_IDX_W-1:0] beat_q, beat_d;
    logic [LA_W-1:0]       line_addr_q, line_addr_d;
    logic                  line_valid_q, line_valid_d;
    logic [ADDR_W-1:0]     hold_addr_q, hold_addr_d;
    logic [63:0]           hold_data_q, hold_data_d;
    logic [7:0]            hold_be_q, hold_be_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [7:0]            burstcnt_q, burstcnt_d;

    logic                  buf_wr;
    logic [LINE_IDX_W-1:0] buf_idx;
    logic [63:0]           buf_data;
    logic [7:0]            buf_be;
    logic                  buf_clr;
    logic [63:0]           buf_rd_data;
    logic [7:0]            buf_rd_be;
    logic                  buf_full;

    logic wr_ok;
    logic same_line;
    logic start;
    logic unused_rd_lo;

    assign wr_ok        = wr_in && !busy_q;
    assign same_line    = wr_addr_in[ADDR_W-1:LINE_IDX_W] == line_addr_q;
    assign unused_rd_lo = ^rd_addr_in[LINE_IDX_W-1:0];

    wc_line_buffer u_buf (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .wr_en_i   (buf_wr),
        .wr_idx_i  (buf_idx),
        .wr_data_i (buf_data),
        .wr_be_i   (buf_be),
        .clr_i     (buf_clr),
        .rd_idx_i  (beat_q),
        .rd_data_o (buf_rd_data),
        .rd_be_o   (buf_rd_be),
        .full_o    (buf_full)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_addr_d  = line_addr_q;
        line_valid_d = line_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        hold_be_d    = hold_be_q;
        hold_valid_d = hold_valid_q;
        we_d         = we_q;
        done_d       = 1'b0;
        addr_d       = addr_q;
        burstcnt_d   = burstcnt_q;
        buf_wr       = 1'b0;
        buf_idx      = wr_addr_in[LINE_IDX_W-1:0];
        buf_data     = wr_data_in;
        buf_be       = wr_be_in;
        buf_clr      = 1'b0;
        start        = 1'b0;

        unique case (state_q)
            WC_IDLE: begin
                if (wr_ok && (!line_valid_q || same_line)) begin
                    buf_wr       = 1'b1;
                    line_addr_d  = wr_addr_in[ADDR_W-1:LINE_IDX_W];
                    line_valid_d = 1'b1;
                    start        = buf_full || flush_in;
                end else if (wr_ok) begin
                    // line change: park the new write, flush the old line
                    hold_addr_d  = wr_addr_in;
                    hold_data_d  = wr_data_in;
                    hold_be_d    = wr_be_in;
                    hold_valid_d = 1'b1;
                    start        = 1'b1;
                end else if (flush_in) begin
                    start  = line_valid_q;
                    done_d = !line_valid_q;
                end
                if (start) begin
                    state_d    = WC_FLUSH;
                    we_d       = 1'b1;
                    beat_d     = '0;
                    addr_d     = {line_addr_d, {LINE_IDX_W{1'b0}}};
                    burstcnt_d = BURST_LEN;
                end
            end
            WC_FLUSH: begin
                if (we_q && !ddram_busy_in) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d      = WC_IDLE;
                        we_d         = 1'b0;
                        done_d       = 1'b1;
                        burstcnt_d   = '0;
                        buf_clr      = 1'b1;
                        line_valid_d = hold_valid_q;
                        if (hold_valid_q) begin
                            buf_wr       = 1'b1;
                            buf_idx      = hold_addr_q[LINE_IDX_W-1:0];
                            buf_data     = hold_data_q;
                            buf_be       = hold_be_q;
                            line_addr_d  = hold_addr_q[ADDR_W-1:LINE_IDX_W];
                            hold_valid_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = WC_IDLE;
        endcase

        busy_d = (state_d == WC_FLUSH) || hold_valid_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WC_IDLE;
            beat_q       <= '0;
            line_addr_q  <= '0;
            line_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            hold_be_q    <= '0;
            hold_valid_q <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            burstcnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            line_addr_q  <= line_addr_d;
            line_valid_q <= line_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            hold_be_q    <= hold_be_d;
            hold_valid_q <= hold_valid_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            addr_q       <= addr_d;
            burstcnt_q   <= burstcnt_d;
        end
    end

    assign rd_hazard_out        = line_valid_q &&
                                  rd_addr_in[ADDR_W-1:LINE_IDX_W] == line_addr_q;
    assign wr_busy_out          = busy_q;
    assign flush_done_out       = done_q;
    assign ddram_addr_out       = addr_q;
    assign ddram_burstcnt_out   = burstcnt_q;
    assign ddram_we_out         = we_q;
    assign ddram_writedata_out  = we_q ? buf_rd_data : '0;
    assign ddram_byteenable_out = we_q ? buf_rd_be : '0;

endmodule

// File: tb/tb_simple_write_combiner.sv
// Scoreboard bench for simple_write_combiner: expected DDR beats are
// queued with the stimulus and compared on every accepted beat.
module tb_simple_write_combiner;

    logic        clock;
    logic        reset_n;
    logic [28:0] wr_addr_in;
    logic [63:0] wr_data_in;
    logic [7:0]  wr_be_in;
    logic        wr_in;
    logic        flush_in;
    logic [28:0] rd_addr_in;
    logic        rd_hazard_out;
    logic        wr_busy_out;
    logic        flush_done_out;
    logic [28:0] ddram_addr_out;
    logic [7:0]  ddram_burstcnt_out;
    logic [63:0] ddram_writedata_out;
    logic [7:0]  ddram_byteenable_out;
    logic        ddram_we_out;
    logic        ddram_busy_in;

    typedef struct {
        logic [28:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } beat_t;

    beat_t sbq[$];
    beat_t mon_b;

    int checks = 0;
    int failures = 0;
    int acc = 0;
    int we_cycles = 0;
    int done_cnt = 0;

    simple_write_combiner dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .wr_addr_in           (wr_addr_in),
        .wr_data_in           (wr_data_in),
        .wr_be_in             (wr_be_in),
        .wr_in                (wr_in),
        .flush_in             (flush_in),
        .rd_addr_in           (rd_addr_in),
        .rd_hazard_out        (rd_hazard_out),
        .wr_busy_out          (wr_busy_out),
        .flush_done_out       (flush_done_out),
        .ddram_addr_out       (ddram_addr_out),
        .ddram_burstcnt_out   (ddram_burstcnt_out),
        .ddram_writedata_out  (ddram_writedata_out),
        .ddram_byteenable_out (ddram_byteenable_out),
        .ddram_we_out         (ddram_we_out),
        .ddram_busy_in        (ddram_busy_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    // beats are accepted on the next rising edge when we && !busy
    always @(negedge clock) begin
        if (reset_n) begin
            if (flush_done_out) done_cnt++;
            if (ddram_we_out) begin
                we_cycles++;
                if (!ddram_busy_in) begin
                    acc++;
                    if (sbq.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        mon_b = sbq.pop_front();
                        check("beat_addr", 64'(ddram_addr_out), 64'(mon_b.addr));
                        check("beat_cnt", 64'(ddram_burstcnt_out), 64'd8);
                        check("beat_be", 64'(ddram_byteenable_out), 64'(mon_b.be));
                        check("beat_data", ddram_writedata_out & be_mask(mon_b.be),
                              mon_b.data & be_mask(mon_b.be));
                    end
                end
            end
        end
    end

    task automatic push_line(input logic [28:0] base, input int idx,
                             input logic [63:0] d, input logic [7:0] be);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.addr = base;
            b.data = (i == idx) ? d : 64'd0;
            b.be   = (i == idx) ? be : 8'h00;
            sbq.push_back(b);
        end
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (wr_busy_out && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (wr_busy_out) check("busy_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wr_busy_out || ddram_we_out) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (wr_busy_out || ddram_we_out) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic write(input logic [28:0] a, input logic [63:0] d,
                         input logic [7:0] be);
        wait_not_busy();
        wr_addr_in = a;
        wr_data_in = d;
        wr_be_in   = be;
        wr_in      = 1'b1;
        @(posedge clock); #1;
        wr_in      = 1'b0;
    endtask

    task automatic flush();
        wait_not_busy();
        flush_in = 1'b1;
        @(posedge clock); #1;
        flush_in = 1'b0;
    endtask

    task automatic clear_counts();
        acc = 0;
        we_cycles = 0;
        done_cnt = 0;
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc < target && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("acc_reached", 64'(acc), 64'(target));
    endtask

    logic [63:0] frz_data;
    logic [7:0]  frz_be;

    initial begin
        reset_n       = 1'b0;
        wr_addr_in    = '0;
        wr_data_in    = '0;
        wr_be_in      = '0;
        wr_in         = 1'b0;
        flush_in      = 1'b0;
        rd_addr_in    = '0;
        ddram_busy_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_we", 64'(ddram_we_out), 64'd0);
        check("rst_busy", 64'(wr_busy_out), 64'd0);
        check("rst_done", 64'(flush_done_out), 64'd0);
        check("rst_addr", 64'(ddram_addr_out), 64'd0);
        check("rst_cnt", 64'(ddram_burstcnt_out), 64'd0);
        check("rst_hazard", 64'(rd_hazard_out), 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // full line fill triggers a burst
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            beat_t b;
            b.addr = 29'h100;
            b.data = 64'hA5A5_0000_0000_0100 + 64'(i);
            b.be   = 8'hFF;
            sbq.push_back(b);
        end
        for (int i = 0; i < 8; i++)
            write(29'h100 + 29'(i), 64'hA5A5_0000_0000_0100 + 64'(i), 8'hFF);
        check("t1_busy", 64'(wr_busy_out), 64'd1);
        wait_idle();
        repeat (2) @(posedge clock);
        #1;
        check("t1_acc", 64'(acc), 64'd8);
        check("t1_we_cycles", 64'(we_cycles), 64'd8);
        check("t1_done", 64'(done_cnt), 64'd1);
        check("t1_hazard", 64'(rd_hazard_out), 64'd0);

        // partial word then explicit flush
        clear_counts();
        push_line(29'h200, 3, 64'h1122_3344_5566_77AA, 8'h0F);
        write(29'h203, 64'h1122_3344_5566_77AA, 8'h0F);
        rd_addr_in = 29'h205;
        #1 check("t2_hazard", 64'(rd_hazard_out), 64'd1);
        flush();
        wait_idle();
        repeat (2) @(posedge clock);
        #1;
        check("t2_acc", 64'(acc), 64'd8);
        check("t2_done", 64'(done_cnt), 64'd1);

        // line change parks the write in the hold register
        clear_counts();
        push_line(29'h300, 0, 64'hDEAD_BEEF_0000_0300, 8'hFF);
        write(29'h300, 64'hDEAD_BEEF_0000_0300, 8'hFF);
        write(29'h408, 64'h0123_4567_89AB_CDEF, 8'h3C);
        check("t3_busy", 64'(wr_busy_out), 64'd1);
        wait_idle();
        rd_addr_in = 29'h40C;
        #1 check("t3_hazard_new", 64'(rd_hazard_out), 64'd1);
        rd_addr_in = 29'h300;
        #1 check("t3_hazard_old", 64'(rd_hazard_out), 64'd0);
        check("t3_acc", 64'(acc), 64'd8);
        push_line(29'h408, 0, 64'h0123_4567_89AB_CDEF, 8'h3C);
        flush();
        wait_idle();
        repeat (2) @(posedge clock);
        #1;
        check("t3_acc2", 64'(acc), 64'd16);

        // controller stall on beat 4
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            beat_t b;
            b.addr = 29'h500;
            b.data = 64'hC0DE_0000_0000_0000 + 64'(i);
            b.be   = 8'hFF;
            sbq.push_back(b);
        end
        for (int i = 0; i < 8; i++)
            write(29'h500 + 29'(i), 64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF);
        wait_acc(4);
        ddram_busy_in = 1'b1;
        frz_data = ddram_writedata_out;
        frz_be   = ddram_byteenable_out;
        check("t4_beat4_data", frz_data, 64'hC0DE_0000_0000_0004);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("t4_frz_data", ddram_writedata_out, frz_data);
            check("t4_frz_be", 64'(ddram_byteenable_out), 64'(frz_be));
            check("t4_frz_we", 64'(ddram_we_out), 64'd1);
        end
        ddram_busy_in = 1'b0;
        wait_idle();
        repeat (2) @(posedge clock);
        #1;
        check("t4_acc", 64'(acc), 64'd8);

        // flush with nothing buffered
        clear_counts();
        flush();
        check("t5_done", 64'(flush_done_out), 64'd1);
        @(posedge clock); #1;
        check("t5_done_pulse", 64'(flush_done_out), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("t5_we_cycles", 64'(we_cycles), 64'd0);

        // reset in the middle of a burst
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            beat_t b;
            b.addr = 29'h600;
            b.data = 64'h6666_0000_0000_0000 + 64'(i);
            b.be   = 8'hFF;
            sbq.push_back(b);
        end
        for (int i = 0; i < 8; i++)
            write(29'h600 + 29'(i), 64'h6666_0000_0000_0000 + 64'(i), 8'hFF);
        wait_acc(2);
        rd_addr_in = 29'h600;
        reset_n = 1'b0;
        #1;
        check("t6_we", 64'(ddram_we_out), 64'd0);
        check("t6_busy", 64'(wr_busy_out), 64'd0);
        check("t6_addr", 64'(ddram_addr_out), 64'd0);
        check("t6_cnt", 64'(ddram_burstcnt_out), 64'd0);
        check("t6_wdata", ddram_writedata_out, 64'd0);
        check("t6_hazard", 64'(rd_hazard_out), 64'd0);
        check("t6_sb_empty", 64'(sbq.size()), 64'd0);
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        clear_counts();
        push_line(29'h700, 0, 64'h7777_0000_0000_00BB, 8'h0F);
        write(29'h700, 64'h7777_0000_0000_00BB, 8'h0F);
        rd_addr_in = 29'h700;
        #1 check("t6_hazard_new", 64'(rd_hazard_out), 64'd1);
        rd_addr_in = 29'h600;
        #1 check("t6_hazard_old", 64'(rd_hazard_out), 64'd0);
        flush();
        wait_idle();
        repeat (2) @(posedge clock);
        #1;
        check("t6_acc", 64'(acc), 64'd8);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
